// File: rtl/rast_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rast_pkg
// Brief    : Shared state type, box indices and sub-sample step helper.
// Revision : 1.0 - initial release
// ============================================================================
package rast_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_t;

    localparam int LL = 0;
    localparam int UR = 1;

    // Any code that is not one-hot falls back to one sample per pixel.
    function automatic logic [31:0] ss_step(input logic [3:0] sub_sample, input int radix);
        logic [31:0] full;
        full = 32'd1 << radix;
        case (sub_sample)
            4'b0100: return full >> 1;
            4'b0010: return full >> 2;
            4'b0001: return full >> 3;
            default: return full;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/samp_row_gen.sv
`default_nettype none
// ============================================================================
// Module   : samp_row_gen
// Brief    : Combinational generator for one group of horizontally adjacent samples.
// Revision : 1.0 - initial release
// ============================================================================
module samp_row_gen
    import rast_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int SAMPS  = 4
) (
    input  logic [SIGFIG-1:0]                 cur_x,
    input  logic [SIGFIG-1:0]                 cur_y,
    input  logic [SIGFIG-1:0]                 step,
    input  logic [SIGFIG-1:0]                 ur_x,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0] pos,
    output logic [SAMPS-1:0]                  valid,
    output logic signed [SIGFIG:0]            nx
);

    // One guard bit keeps sums past the right screen edge from wrapping negative.
    logic signed [SIGFIG:0] w_x_ext;
    logic signed [SIGFIG:0] w_step_ext;
    logic signed [SIGFIG:0] w_ur_ext;

    assign w_x_ext    = {cur_x[SIGFIG-1], cur_x};
    assign w_step_ext = {1'b0, step};
    assign w_ur_ext   = {ur_x[SIGFIG-1], ur_x};
    assign nx         = w_x_ext + w_step_ext * (SIGFIG+1)'(SAMPS);

    for (genvar s = 0; s < SAMPS; s++) begin : g_lane
        logic signed [SIGFIG:0] w_sum;
        assign w_sum     = w_x_ext + w_step_ext * (SIGFIG+1)'(s);
        assign pos[0][s] = w_sum[SIGFIG-1:0];
        assign pos[1][s] = cur_y;
        assign valid[s]  = (w_sum <= w_ur_ext);
    end

endmodule
`default_nettype wire

// File: rtl/samp_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : samp_iter_ctrl
// Brief    : Walks a triangle's bounding box row-major, SAMPS samples per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module samp_iter_ctrl
    import rast_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R14S,
    input  logic                                  validTri_R14H,
    input  logic [3:0]                            subSample_RnnnnU,
    output logic                                  halt_RnnnnH,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R16U,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R16S,
    output logic [SAMPS-1:0]                      validSamp_R16H
);

    iter_state_t                            state_q, state_d;
    logic [SIGFIG-1:0]                      cur_x_q, cur_x_d;
    logic [SIGFIG-1:0]                      cur_y_q, cur_y_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic [1:0][1:0][SIGFIG-1:0]            box_q, box_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;

    logic [1:0][SAMPS-1:0][SIGFIG-1:0]      w_pos;
    logic [SAMPS-1:0]                       w_valid;
    logic signed [SIGFIG:0]                 w_nx;
    logic signed [SIGFIG:0]                 w_ny;
    logic signed [SIGFIG:0]                 w_ur_x;
    logic signed [SIGFIG:0]                 w_ur_y;
    logic                                   w_row_done;
    logic                                   w_last;
    logic                                   w_accept;
    logic                                   w_degen;

    samp_row_gen #(
        .SIGFIG (SIGFIG),
        .SAMPS  (SAMPS)
    ) u_row_gen (
        .cur_x  (cur_x_q),
        .cur_y  (cur_y_q),
        .step   (step_q),
        .ur_x   (box_q[UR][0]),
        .pos    (w_pos),
        .valid  (w_valid),
        .nx     (w_nx)
    );

    assign w_ur_x     = {box_q[UR][0][SIGFIG-1], box_q[UR][0]};
    assign w_ur_y     = {box_q[UR][1][SIGFIG-1], box_q[UR][1]};
    assign w_ny       = {cur_y_q[SIGFIG-1], cur_y_q} + {1'b0, step_q};
    assign w_row_done = (w_nx > w_ur_x);
    assign w_last     = w_row_done & (w_ny > w_ur_y);

    // Derived only from flops so upstream never sees a combinational loop.
    assign halt_RnnnnH = (state_q == TEST) & ~w_last;
    assign w_accept    = validTri_R14H & ~halt_RnnnnH;
    assign w_degen     = ($signed(box_R14S[LL][0]) > $signed(box_R14S[UR][0])) |
                         ($signed(box_R14S[LL][1]) > $signed(box_R14S[UR][1]));

    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        step_d  = step_q;
        box_d   = box_q;
        tri_d   = tri_q;
        color_d = color_q;

        if (state_q == TEST) begin
            if (w_last) begin
                state_d = WAIT;
            end else if (w_row_done) begin
                cur_x_d = box_q[LL][0];
                cur_y_d = w_ny[SIGFIG-1:0];
            end else begin
                cur_x_d = w_nx[SIGFIG-1:0];
            end
        end

        // A new triangle overrides the finishing one for zero-bubble hand-over.
        if (w_accept) begin
            if (w_degen) begin
                state_d = WAIT;
            end else begin
                state_d = TEST;
                tri_d   = tri_R14S;
                color_d = color_R14U;
                box_d   = box_R14S;
                step_d  = SIGFIG'(ss_step(subSample_RnnnnU, RADIX));
                cur_x_d = box_R14S[LL][0];
                cur_y_d = box_R14S[LL][1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            cur_x_q <= '0;
            cur_y_q <= '0;
            step_q  <= '0;
            box_q   <= '0;
            tri_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            step_q  <= step_d;
            box_q   <= box_d;
            tri_q   <= tri_d;
            color_q <= color_d;
        end
    end

    assign tri_R16S       = tri_q;
    assign color_R16U     = color_q;
    assign sample_R16S    = (state_q == TEST) ? w_pos : '0;
    assign validSamp_R16H = (state_q == TEST) ? w_valid : '0;

endmodule
`default_nettype wire

// File: tb/tb_samp_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_samp_iter_ctrl
// Brief    : Directed and randomized self-checking bench for samp_iter_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_samp_iter_ctrl;

    localparam int     SIGFIG = 24;
    localparam int     RADIX  = 10;
    localparam int     VERTS  = 3;
    localparam int     AXIS   = 3;
    localparam int     COLORS = 3;
    localparam int     SAMPS  = 4;
    localparam longint P      = 1024;
    localparam int     NRAND  = 40;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
    typedef logic [SAMPS-1:0][SIGFIG-1:0]           row_t;

    typedef struct {
        longint           x;
        longint           y;
        longint           step;
        logic [SAMPS-1:0] mask;
        bit               last;
        int               tag;
    } grp_t;

    logic                              clk;
    logic                              rst;
    tri_t                              tri_R14S;
    col_t                              color_R14U;
    logic [1:0][1:0][SIGFIG-1:0]       box_R14S;
    logic                              validTri_R14H;
    logic [3:0]                        subSample_RnnnnU;
    logic                              halt_RnnnnH;
    tri_t                              tri_R16S;
    col_t                              color_R16U;
    logic [1:0][SAMPS-1:0][SIGFIG-1:0] sample_R16S;
    logic [SAMPS-1:0]                  validSamp_R16H;

    int     n_checks = 0;
    int     n_pass   = 0;
    grp_t   exp_q[$];
    longint d_llx, d_lly, d_urx, d_ury, d_step;
    int     d_tag;
    logic [3:0] ss_tab [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 4'b0011};

    samp_iter_ctrl #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS),
        .SAMPS  (SAMPS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .box_R14S         (box_R14S),
        .validTri_R14H    (validTri_R14H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnH      (halt_RnnnnH),
        .tri_R16S         (tri_R16S),
        .color_R16U       (color_R16U),
        .sample_R16S      (sample_R16S),
        .validSamp_R16H   (validSamp_R16H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tri_t make_tri(input int tag);
        tri_t t;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                t[v][a] = SIGFIG'(tag * 16 + v * 4 + a);
        return t;
    endfunction

    function automatic col_t make_col(input int tag);
        col_t c;
        for (int i = 0; i < COLORS; i++) c[i] = SIGFIG'(tag * 8 + i + 3);
        return c;
    endfunction

    function automatic row_t row_x(input longint x, input longint step);
        row_t r;
        for (int s = 0; s < SAMPS; s++) r[s] = SIGFIG'(x + s * step);
        return r;
    endfunction

    function automatic row_t row_y(input longint y);
        row_t r;
        for (int s = 0; s < SAMPS; s++) r[s] = SIGFIG'(y);
        return r;
    endfunction

    function automatic longint step_of(input logic [3:0] ss);
        case (ss)
            4'b0100: return P / 2;
            4'b0010: return P / 4;
            4'b0001: return P / 8;
            default: return P;
        endcase
    endfunction

    task automatic drive_tri(input longint llx, input longint lly, input longint urx,
                             input longint ury, input logic [3:0] ss, input int tag);
        box_R14S[0][0]   = SIGFIG'(llx);
        box_R14S[0][1]   = SIGFIG'(lly);
        box_R14S[1][0]   = SIGFIG'(urx);
        box_R14S[1][1]   = SIGFIG'(ury);
        subSample_RnnnnU = ss;
        tri_R14S         = make_tri(tag);
        color_R14U       = make_col(tag);
        validTri_R14H    = 1'b1;
        d_llx = llx; d_lly = lly; d_urx = urx; d_ury = ury;
        d_step = step_of(ss); d_tag = tag;
    endtask

    // Reference: enumerate every row, then every SAMPS-wide group within it.
    task automatic model_tri();
        grp_t g;
        if (d_llx > d_urx || d_lly > d_ury) return;
        for (longint y = d_lly; y <= d_ury; y += d_step) begin
            for (longint x = d_llx; x <= d_urx; x += SAMPS * d_step) begin
                g.x = x; g.y = y; g.step = d_step; g.tag = d_tag;
                for (int s = 0; s < SAMPS; s++) g.mask[s] = (x + s * d_step <= d_urx);
                g.last = (x + SAMPS * d_step > d_urx) && (y + d_step > d_ury);
                exp_q.push_back(g);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        validTri_R14H = 1'b0;
        subSample_RnnnnU = 4'b1000;
        box_R14S = '0; tri_R14S = '0; color_R14U = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (validSamp_R16H !== '0) $display("FAIL reset_valid got %b want 0", validSamp_R16H); else n_pass++;
        n_checks++; if (halt_RnnnnH !== 1'b0) $display("FAIL reset_halt got %b want 0", halt_RnnnnH); else n_pass++;
        n_checks++; if (sample_R16S !== '0) $display("FAIL reset_sample got %h want 0", sample_R16S); else n_pass++;
        n_checks++; if (tri_R16S !== '0 || color_R16U !== '0) $display("FAIL reset_tri_color got %h/%h want 0", tri_R16S, color_R16U); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk); drive_tri(0, 0, 3*P, P, 4'b1000, 1);
        @(negedge clk); validTri_R14H = 1'b0;
        n_checks++; if (validSamp_R16H !== 4'b1111) $display("FAIL basic_g1_valid got %b want 1111", validSamp_R16H); else n_pass++;
        n_checks++; if (halt_RnnnnH !== 1'b1) $display("FAIL basic_g1_halt got %b want 1", halt_RnnnnH); else n_pass++;
        n_checks++; if (sample_R16S[0] !== row_x(0, P)) $display("FAIL basic_g1_x got %h want %h", sample_R16S[0], row_x(0, P)); else n_pass++;
        n_checks++; if (sample_R16S[1] !== row_y(0)) $display("FAIL basic_g1_y got %h want %h", sample_R16S[1], row_y(0)); else n_pass++;
        n_checks++; if (tri_R16S !== make_tri(1) || color_R16U !== make_col(1)) $display("FAIL basic_tri got %h want %h", tri_R16S, make_tri(1)); else n_pass++;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== 4'b1111) $display("FAIL basic_g2_valid got %b want 1111", validSamp_R16H); else n_pass++;
        n_checks++; if (halt_RnnnnH !== 1'b0) $display("FAIL basic_g2_halt got %b want 0", halt_RnnnnH); else n_pass++;
        n_checks++; if (sample_R16S[1] !== row_y(P) || sample_R16S[0] !== row_x(0, P)) $display("FAIL basic_g2_pos got %h want y=%h", sample_R16S, row_y(P)); else n_pass++;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL basic_wait got %b/%b want 0000/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
    endtask

    task automatic test_row_overflow();
        @(negedge clk); drive_tri(0, 0, 4*P, 0, 4'b1000, 2);
        @(negedge clk); validTri_R14H = 1'b0;
        n_checks++; if (validSamp_R16H !== 4'b1111 || halt_RnnnnH !== 1'b1) $display("FAIL ovf_g1 got %b/%b want 1111/1", validSamp_R16H, halt_RnnnnH); else n_pass++;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== 4'b0001) $display("FAIL ovf_g2_valid got %b want 0001", validSamp_R16H); else n_pass++;
        n_checks++; if (halt_RnnnnH !== 1'b0) $display("FAIL ovf_g2_halt got %b want 0", halt_RnnnnH); else n_pass++;
        n_checks++; if (sample_R16S[0] !== row_x(4*P, P)) $display("FAIL ovf_g2_x got %h want %h", sample_R16S[0], row_x(4*P, P)); else n_pass++;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== '0) $display("FAIL ovf_wait got %b want 0000", validSamp_R16H); else n_pass++;
    endtask

    task automatic test_4spp();
        @(negedge clk); drive_tri(0, 0, 3*P/2, 0, 4'b0100, 3);
        @(negedge clk); validTri_R14H = 1'b0;
        n_checks++; if (validSamp_R16H !== 4'b1111 || halt_RnnnnH !== 1'b0) $display("FAIL spp4_g1 got %b/%b want 1111/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
        n_checks++; if (sample_R16S[0] !== row_x(0, P/2)) $display("FAIL spp4_x got %h want %h", sample_R16S[0], row_x(0, P/2)); else n_pass++;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== '0) $display("FAIL spp4_wait got %b want 0000", validSamp_R16H); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drive_tri(0, 0, 3*P, P, 4'b1000, 5);
        @(negedge clk); drive_tri(0, 2*P, 3*P, 2*P, 4'b1000, 6);
        n_checks++; if (halt_RnnnnH !== 1'b1 || tri_R16S !== make_tri(5)) $display("FAIL b2b_g1 got halt %b tri %h want 1/%h", halt_RnnnnH, tri_R16S, make_tri(5)); else n_pass++;
        @(negedge clk);
        n_checks++; if (sample_R16S[1] !== row_y(P) || tri_R16S !== make_tri(5)) $display("FAIL b2b_a_last got %h want y=%h", sample_R16S[1], row_y(P)); else n_pass++;
        n_checks++; if (halt_RnnnnH !== 1'b0) $display("FAIL b2b_a_last_halt got %b want 0", halt_RnnnnH); else n_pass++;
        @(negedge clk); validTri_R14H = 1'b0;
        n_checks++; if (validSamp_R16H !== 4'b1111 || sample_R16S[1] !== row_y(2*P)) $display("FAIL b2b_b_g1 got %b y %h want 1111 y %h", validSamp_R16H, sample_R16S[1], row_y(2*P)); else n_pass++;
        n_checks++; if (tri_R16S !== make_tri(6) || color_R16U !== make_col(6)) $display("FAIL b2b_b_tri got %h want %h", tri_R16S, make_tri(6)); else n_pass++;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL b2b_wait got %b/%b want 0000/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
    endtask

    task automatic test_degenerate();
        @(negedge clk); drive_tri(5*P, 0, 2*P, 0, 4'b1000, 9);
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL degen_x got %b/%b want 0000/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
        end
        drive_tri(0, 3*P, 3*P, P, 4'b1000, 10);
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL degen_y got %b/%b want 0000/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
        end
        drive_tri(0, 0, 0, 0, 4'b1000, 11);
        @(negedge clk); validTri_R14H = 1'b0;
        n_checks++; if (validSamp_R16H !== 4'b0001 || halt_RnnnnH !== 1'b0) $display("FAIL degen_recover got %b/%b want 0001/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive_tri(0, 0, 15*P, 3*P, 4'b1000, 7);
        @(negedge clk); validTri_R14H = 1'b0;
        n_checks++; if (validSamp_R16H !== 4'b1111 || halt_RnnnnH !== 1'b1) $display("FAIL rstmid_g1 got %b/%b want 1111/1", validSamp_R16H, halt_RnnnnH); else n_pass++;
        @(negedge clk);
        n_checks++; if (sample_R16S[0] !== row_x(4*P, P)) $display("FAIL rstmid_g2_x got %h want %h", sample_R16S[0], row_x(4*P, P)); else n_pass++;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL rstmid_ctrl got %b/%b want 0000/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
            n_checks++; if (sample_R16S !== '0 || tri_R16S !== '0 || color_R16U !== '0) $display("FAIL rstmid_data got %h/%h want 0", sample_R16S, tri_R16S); else n_pass++;
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL rstmid_after got %b/%b want 0000/0", validSamp_R16H, halt_RnnnnH); else n_pass++;
    endtask

    task automatic test_random();
        grp_t   g;
        bit     consumed = 1'b0;
        bit     exp_halt;
        bit     done = 1'b0;
        int     gap = 0;
        int     sent = 0;
        longint st, llx, lly, urx, ury;
        logic [3:0] ss;
        exp_q.delete();
        validTri_R14H = 1'b0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                g = exp_q.pop_front();
                exp_halt = !g.last;
                n_checks++; if (validSamp_R16H !== g.mask) $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, validSamp_R16H, g.mask); else n_pass++;
                n_checks++; if (halt_RnnnnH !== exp_halt) $display("FAIL rnd_halt cyc %0d got %b want %b", cyc, halt_RnnnnH, exp_halt); else n_pass++;
                n_checks++; if (sample_R16S[0] !== row_x(g.x, g.step)) $display("FAIL rnd_x cyc %0d got %h want %h", cyc, sample_R16S[0], row_x(g.x, g.step)); else n_pass++;
                n_checks++; if (sample_R16S[1] !== row_y(g.y)) $display("FAIL rnd_y cyc %0d got %h want %h", cyc, sample_R16S[1], row_y(g.y)); else n_pass++;
                n_checks++; if (tri_R16S !== make_tri(g.tag)) $display("FAIL rnd_tri cyc %0d got %h want %h", cyc, tri_R16S, make_tri(g.tag)); else n_pass++;
            end else begin
                exp_halt = 1'b0;
                n_checks++; if (validSamp_R16H !== '0 || halt_RnnnnH !== 1'b0) $display("FAIL rnd_idle cyc %0d got %b/%b want 0000/0", cyc, validSamp_R16H, halt_RnnnnH); else n_pass++;
            end
            if (consumed) begin
                validTri_R14H = 1'b0;
                consumed = 1'b0;
            end
            if (!validTri_R14H && sent < NRAND) begin
                if (gap == 0) begin
                    ss  = ss_tab[$urandom_range(0, 6)];
                    st  = step_of(ss);
                    llx = longint'(int'($urandom_range(0, 16)) - 8) * st;
                    urx = llx + longint'($urandom_range(0, 9)) * st;
                    if ($urandom_range(0, 5) == 0) begin
                        urx = 64'd8388607;
                        llx = urx - longint'($urandom_range(0, 9)) * st;
                    end
                    lly = longint'(int'($urandom_range(0, 8)) - 4) * st;
                    ury = lly + longint'($urandom_range(0, 4)) * st;
                    if ($urandom_range(0, 7) == 0) begin
                        if ($urandom_range(0, 1) == 0) urx = llx - st;
                        else ury = lly - st;
                    end
                    drive_tri(llx, lly, urx, ury, ss, 100 + sent);
                    sent++;
                    gap = $urandom_range(0, 2);
                end else begin
                    gap--;
                end
            end
            if (validTri_R14H && !exp_halt) begin
                model_tri();
                consumed = 1'b1;
            end
            done = (sent == NRAND) && !validTri_R14H && !consumed && (exp_q.size() == 0);
        end
        n_checks++; if (!done) $display("FAIL rnd_timeout got sent=%0d pending=%0d want all drained", sent, exp_q.size()); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_row_overflow();
        test_4spp();
        test_back_to_back();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
